// File: rtl/dm9000a_bus_sequencer_pkg.sv
// dm9000a_bus_sequencer_pkg: FSM states, DM9000A register indices and default bus timing
package dm9000a_bus_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE, IDX_SETUP, IDX_STROBE, IDX_RECOV, DAT_SETUP, DAT_STROBE, DAT_RECOV, DONE
   } state_t;

   localparam logic [7:0] REG_NCR   = 8'h00;
   localparam logic [7:0] REG_NSR   = 8'h01;
   localparam logic [7:0] REG_VID   = 8'h28;
   localparam logic [7:0] REG_MRCMD = 8'hF2;
   localparam logic [7:0] REG_MWCMD = 8'hF8;
   localparam logic [7:0] REG_ISR   = 8'hFE;

   localparam int DEF_SETUP_CYC  = 1;
   localparam int DEF_STROBE_CYC = 2;
   localparam int DEF_RECOV_CYC  = 2;
   localparam int DEF_CNT_W      = 11;

   // Timer must hold the largest phase length minus one
   function automatic int timer_w(input int s, input int t, input int r);
      int m;
      m = (s > t) ? s : t;
      m = (m > r) ? m : r;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/dm9000a_phase_timer.sv
// dm9000a_phase_timer: loadable down-counter timing every bus phase
module dm9000a_phase_timer #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt;

   assign expired = (cnt == '0);

   // Load wins over counting; the counter parks at zero once expired
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (load) cnt <= load_val;
      else if (en && cnt != '0) cnt <= cnt - 1'b1;

endmodule

// File: rtl/dm9000a_bus_sequencer.sv
// dm9000a_bus_sequencer: turns register/FIFO requests into timed index-then-data DM9000A bus cycles
module dm9000a_bus_sequencer
   import dm9000a_bus_sequencer_pkg::*;
#(
   parameter int SETUP_CYC  = DEF_SETUP_CYC,
   parameter int STROBE_CYC = DEF_STROBE_CYC,
   parameter int RECOV_CYC  = DEF_RECOV_CYC,
   parameter int CNT_W      = DEF_CNT_W
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [7:0]       req_index,
   input  logic [CNT_W-1:0] req_count,
   input  logic             wr_valid,
   output logic             wr_ready,
   input  logic [15:0]      wr_data,
   output logic             rd_valid,
   output logic [15:0]      rd_data,
   output logic             done,
   output logic             oCMD,
   output logic             oCS_N,
   output logic             oRD_N,
   output logic             oWR_N,
   output logic [15:0]      oDATA,
   input  logic [15:0]      iDATA
);

   localparam int TW = timer_w(SETUP_CYC, STROBE_CYC, RECOV_CYC);

   state_t           state;
   logic             write;
   logic [CNT_W-1:0] remaining;
   logic             accept;
   logic             t_load;
   logic             t_exp;
   logic [TW-1:0]    t_val;

   assign accept = req_valid && req_ready;

   // Reload the timer on every phase change; freeze it while a write word is awaited
   always_comb begin
      t_load = (state == IDLE) ? accept : (state != DONE) && !wr_ready && t_exp;
      t_val  = (state == IDX_SETUP  || state == DAT_SETUP)  ? TW'(STROBE_CYC - 1) :
               (state == IDX_STROBE || state == DAT_STROBE) ? TW'(RECOV_CYC - 1) :
                                                              TW'(SETUP_CYC - 1);
   end

   dm9000a_phase_timer #(.W(TW)) u_timer (
      .clk      (iCLK),
      .rst_n    (iRST_N),
      .load     (t_load),
      .en       (!wr_ready),
      .load_val (t_val),
      .expired  (t_exp)
   );

   // Bus sequencer: state and every output registered together
   always_ff @(posedge iCLK or negedge iRST_N)
      if (!iRST_N) begin
         state     <= IDLE;
         write     <= 1'b0;
         remaining <= '0;
         req_ready <= 1'b0;
         wr_ready  <= 1'b0;
         rd_valid  <= 1'b0;
         rd_data   <= '0;
         done      <= 1'b0;
         oCMD      <= 1'b0;
         oCS_N     <= 1'b1;
         oRD_N     <= 1'b1;
         oWR_N     <= 1'b1;
         oDATA     <= '0;
      end else begin
         rd_valid <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               req_ready <= 1'b1;
               if (accept) begin
                  req_ready <= 1'b0;
                  write     <= req_write;
                  remaining <= (req_count == '0) ? CNT_W'(1) : req_count;
                  oDATA     <= {8'h00, req_index};
                  oCMD      <= 1'b0;
                  oCS_N     <= 1'b0;
                  state     <= IDX_SETUP;
               end
            end
            IDX_SETUP: if (t_exp) begin
               oWR_N <= 1'b0;
               state <= IDX_STROBE;
            end
            IDX_STROBE: if (t_exp) begin
               oWR_N <= 1'b1;
               state <= IDX_RECOV;
            end
            IDX_RECOV: if (t_exp) begin
               oCMD     <= 1'b1;
               wr_ready <= write;
               state    <= DAT_SETUP;
            end
            DAT_SETUP:
               if (wr_ready) begin
                  if (wr_valid) begin
                     oDATA    <= wr_data;
                     wr_ready <= 1'b0;
                  end
               end else if (t_exp) begin
                  oWR_N <= !write;
                  oRD_N <= write;
                  state <= DAT_STROBE;
               end
            DAT_STROBE: if (t_exp) begin
               oWR_N    <= 1'b1;
               oRD_N    <= 1'b1;
               rd_valid <= !write;
               if (!write) rd_data <= iDATA;
               state    <= DAT_RECOV;
            end
            DAT_RECOV: if (t_exp) begin
               if (remaining > CNT_W'(1)) begin
                  remaining <= remaining - 1'b1;
                  wr_ready  <= write;
                  state     <= DAT_SETUP;
               end else begin
                  oCS_N <= 1'b1;
                  oCMD  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               done      <= 1'b1;
               req_ready <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_dm9000a_bus_sequencer.sv
// tb_dm9000a_bus_sequencer: directed self-checking bench with bus protocol monitor
module tb_dm9000a_bus_sequencer;

   localparam int S = 1;
   localparam int T = 2;
   localparam int R = 2;

   logic        iCLK = 1'b0;
   logic        iRST_N;
   logic        req_valid, req_ready, req_write;
   logic [7:0]  req_index;
   logic [10:0] req_count;
   logic        wr_valid, wr_ready;
   logic [15:0] wr_data;
   logic        rd_valid;
   logic [15:0] rd_data;
   logic        done, oCMD, oCS_N, oRD_N, oWR_N;
   logic [15:0] oDATA, iDATA;
   logic [15:0] rd_word;

   int checks = 0;
   int errors = 0;

   int idx_wr = 0, dat_wr = 0, dat_rd = 0, rdv = 0, dones = 0, acc = 0;
   logic [15:0] last_idx = 16'h0, last_rd = 16'h0, held = 16'h0;
   logic [15:0] wlog [64];

   int b_idx, b_dwr, b_drd, b_rdv, b_done, b_acc;
   int lat, csh;
   bit found;

   logic [15:0] words [4];
   int nwords, stall_at, gen;
   int seen_gen = 0, wptr = 0, stall_cnt = 0;
   bit hs_pend = 0, st_pend = 0;

   always #5 iCLK = ~iCLK;

   assign iDATA = (!oCS_N && oCMD && !oRD_N) ? rd_word : 16'hDEAD;

   dm9000a_bus_sequencer dut (
      .iCLK(iCLK), .iRST_N(iRST_N),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_index(req_index), .req_count(req_count),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
      .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
      .oCMD(oCMD), .oCS_N(oCS_N), .oRD_N(oRD_N), .oWR_N(oWR_N),
      .oDATA(oDATA), .iDATA(iDATA)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic snap();
      b_idx = idx_wr; b_dwr = dat_wr; b_drd = dat_rd;
      b_rdv = rdv; b_done = dones; b_acc = acc;
   endtask

   task automatic do_txn(input bit w, input logic [7:0] idx, input logic [10:0] cnt,
                         input bit poke, output int l, output int c);
      @(negedge iCLK);
      gen++;
      req_write = w; req_index = idx; req_count = cnt; req_valid = 1'b1;
      @(negedge iCLK);
      req_valid = 1'b0;
      l = -1; c = 0;
      for (int i = 0; i < 300; i++) begin
         if (done) begin l = i; break; end
         if (oCS_N) c++;
         if (poke && i == 3) begin req_valid = 1'b1; req_index = 8'h55; end
         if (poke && i == 6) req_valid = 1'b0;
         @(negedge iCLK);
      end
      @(negedge iCLK);
   endtask

   always @(posedge iCLK) if (req_valid && req_ready) acc++;

   // Write-word source with an optional stall of five DUT-sampled cycles before word stall_at
   always @(negedge iCLK) begin
      if (gen != seen_gen) begin
         seen_gen = gen; wptr = 0; stall_cnt = 0; hs_pend = 0; st_pend = 0;
      end else begin
         if (hs_pend) wptr++;
         if (st_pend) stall_cnt++;
      end
      wr_valid = (wptr < nwords) && !(wptr == stall_at && stall_cnt < 5);
      wr_data  = (wptr < 4) ? words[wptr] : 16'h0000;
      hs_pend  = wr_valid && wr_ready && iRST_N;
      st_pend  = wr_ready && !wr_valid && wptr == stall_at && iRST_N;
   end

   // Bus monitor: strobe overlap, width, gap, data hold, event counts
   logic prev_wr = 1'b1, prev_rd = 1'b1, prev_stb = 1'b1;
   int lo = 0, hi = 0;
   bit seen = 0;
   always @(negedge iCLK) begin
      if (!iRST_N) begin
         prev_wr = 1'b1; prev_rd = 1'b1; prev_stb = 1'b1; lo = 0; hi = 0; seen = 0;
      end else begin
         chk("no_overlap", 32'(oRD_N | oWR_N), 1);
         if (!oWR_N && prev_wr) begin
            if (oCMD) begin wlog[dat_wr] = oDATA; dat_wr++; end
            else begin last_idx = oDATA; idx_wr++; end
            held = oDATA;
         end
         if (!oWR_N && !prev_wr) chk("odata_hold", 32'(oDATA), 32'(held));
         if (!oRD_N && prev_rd) dat_rd++;
         if (rd_valid) begin rdv++; last_rd = rd_data; end
         if (done) dones++;
         if (!(oRD_N & oWR_N)) begin
            if (prev_stb) begin
               if (seen) chk("strobe_gap", 32'(hi >= R + S), 1);
               lo = 0;
            end
            lo++;
         end else begin
            if (!prev_stb) begin
               chk("strobe_width", 32'(lo), 32'(T));
               seen = 1; hi = 0;
            end
            hi++;
         end
         prev_wr = oWR_N; prev_rd = oRD_N; prev_stb = oRD_N & oWR_N;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      iRST_N = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_index = 8'h00; req_count = 11'd0;
      rd_word = 16'h0000; gen = 0; nwords = 0; stall_at = 9;
      for (int i = 0; i < 4; i++) words[i] = 16'h0000;
      #3 iRST_N = 1'b0;
      repeat (3) @(negedge iCLK);
      chk("rst_cs_n", 32'(oCS_N), 1);
      chk("rst_rd_n", 32'(oRD_N), 1);
      chk("rst_wr_n", 32'(oWR_N), 1);
      chk("rst_cmd", 32'(oCMD), 0);
      chk("rst_odata", 32'(oDATA), 0);
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_wr_ready", 32'(wr_ready), 0);
      chk("rst_rd_valid", 32'(rd_valid), 0);
      chk("rst_rd_data", 32'(rd_data), 0);
      chk("rst_done", 32'(done), 0);
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);
      chk("ready_after_reset", 32'(req_ready), 1);

      // Single read of VID
      rd_word = 16'h0A46; nwords = 0; snap();
      do_txn(1'b0, 8'h28, 11'd1, 1'b0, lat, csh);
      chk("rd1_latency", 32'(lat), 11);
      chk("rd1_cs_high", 32'(csh), 1);
      chk("rd1_rd_valid_cnt", 32'(rdv - b_rdv), 1);
      chk("rd1_rd_data", 32'(last_rd), 32'h0A46);
      chk("rd1_idx_strobes", 32'(idx_wr - b_idx), 1);
      chk("rd1_idx_data", 32'(last_idx), 32'h0028);
      chk("rd1_rd_strobes", 32'(dat_rd - b_drd), 1);
      chk("rd1_wr_data_strobes", 32'(dat_wr - b_dwr), 0);
      chk("rd1_done_cnt", 32'(dones - b_done), 1);

      // Single write of ISR
      words[0] = 16'h003F; nwords = 1; stall_at = 9; snap();
      do_txn(1'b1, 8'hFE, 11'd1, 1'b0, lat, csh);
      chk("wr1_latency", 32'(lat), 12);
      chk("wr1_idx_strobes", 32'(idx_wr - b_idx), 1);
      chk("wr1_idx_data", 32'(last_idx), 32'h00FE);
      chk("wr1_data_strobes", 32'(dat_wr - b_dwr), 1);
      chk("wr1_data", 32'(wlog[b_dwr]), 32'h003F);
      chk("wr1_no_rd_valid", 32'(rdv - b_rdv), 0);
      chk("wr1_done_cnt", 32'(dones - b_done), 1);

      // Write burst to MWCMD with a stall before word 3
      words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;
      nwords = 4; stall_at = 2; snap();
      do_txn(1'b1, 8'hF8, 11'd4, 1'b0, lat, csh);
      chk("wrb_latency", 32'(lat), 35);
      chk("wrb_cs_high", 32'(csh), 1);
      chk("wrb_idx_strobes", 32'(idx_wr - b_idx), 1);
      chk("wrb_idx_data", 32'(last_idx), 32'h00F8);
      chk("wrb_data_strobes", 32'(dat_wr - b_dwr), 4);
      chk("wrb_word0", 32'(wlog[b_dwr]), 32'h1111);
      chk("wrb_word1", 32'(wlog[b_dwr + 1]), 32'h2222);
      chk("wrb_word2", 32'(wlog[b_dwr + 2]), 32'h3333);
      chk("wrb_word3", 32'(wlog[b_dwr + 3]), 32'h4444);
      chk("wrb_no_rd_valid", 32'(rdv - b_rdv), 0);
      chk("wrb_done_cnt", 32'(dones - b_done), 1);

      // Read of MRCMD with count 0, plus a request poked while busy
      rd_word = 16'h1234; nwords = 0; stall_at = 9; snap();
      do_txn(1'b0, 8'hF2, 11'd0, 1'b1, lat, csh);
      chk("rd0_latency", 32'(lat), 11);
      chk("rd0_rd_strobes", 32'(dat_rd - b_drd), 1);
      chk("rd0_rd_valid_cnt", 32'(rdv - b_rdv), 1);
      chk("rd0_rd_data", 32'(last_rd), 32'h1234);
      chk("rd0_idx_data", 32'(last_idx), 32'h00F2);
      chk("busy_req_ignored", 32'(acc - b_acc), 1);
      chk("rd0_done_cnt", 32'(dones - b_done), 1);

      // Reset during a burst data strobe
      words[0] = 16'h5555; words[1] = 16'h6666; words[2] = 16'h7777; words[3] = 16'h8888;
      nwords = 4; stall_at = 9;
      @(negedge iCLK);
      gen++;
      req_write = 1'b1; req_index = 8'hF8; req_count = 11'd4; req_valid = 1'b1;
      @(negedge iCLK);
      req_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge iCLK);
         if (!oWR_N && oCMD) begin found = 1; break; end
      end
      chk("abort_reach_strobe", 32'(found), 1);
      #2 iRST_N = 1'b0;
      #1;
      chk("abort_cs_n", 32'(oCS_N), 1);
      chk("abort_wr_n", 32'(oWR_N), 1);
      chk("abort_rd_n", 32'(oRD_N), 1);
      chk("abort_cmd", 32'(oCMD), 0);
      chk("abort_odata", 32'(oDATA), 0);
      chk("abort_req_ready", 32'(req_ready), 0);
      chk("abort_wr_ready", 32'(wr_ready), 0);
      chk("abort_done", 32'(done), 0);
      repeat (2) @(negedge iCLK);
      chk("abort_ready_in_reset", 32'(req_ready), 0);
      iRST_N = 1'b1;
      repeat (2) @(negedge iCLK);
      rd_word = 16'h0BEE; nwords = 0; snap();
      do_txn(1'b0, 8'h01, 11'd1, 1'b0, lat, csh);
      chk("post_latency", 32'(lat), 11);
      chk("post_idx_strobes", 32'(idx_wr - b_idx), 1);
      chk("post_idx_data", 32'(last_idx), 32'h0001);
      chk("post_rd_valid_cnt", 32'(rdv - b_rdv), 1);
      chk("post_rd_data", 32'(last_rd), 32'h0BEE);
      chk("post_done_cnt", 32'(dones - b_done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
